// File: rtl/adsr_envelope_pkg.sv
// Shared types and constants for the amplitude envelope stage.
package adsr_envelope_pkg;

   typedef enum logic [2:0] {
      ENV_IDLE,
      ENV_ATTACK,
      ENV_DECAY,
      ENV_SUSTAIN,
      ENV_RELEASE
   } env_state_t;

   localparam logic [7:0] MIDSCALE = 8'd128;

endpackage

// File: rtl/adsr_envelope_env_tick_gen.sv
// Envelope time base: one-clk tick every TICK_DIV clocks, held off while en is low.
module env_tick_gen #(
   parameter int TICK_DIV = 12000
) (
   input  logic clk,
   input  logic n_rst,
   input  logic en,
   output logic tick
);

   localparam int CNT_W = $clog2(TICK_DIV);
   localparam logic [CNT_W-1:0] TERM_CNT = CNT_W'(TICK_DIV - 1);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   // Counter wraps at terminal count; disabled counter restarts from zero.
   always_comb begin
      count_d = count_q;
      tick    = 1'b0;
      if (!en) begin
         count_d = '0;
      end else if (count_q == TERM_CNT) begin
         count_d = '0;
         tick    = 1'b1;
      end else begin
         count_d = count_q + CNT_W'(1);
      end
   end

   // Counter register.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/adsr_envelope.sv
// ADSR amplitude envelope: gate-driven level FSM plus midscale-centred sample scaler.
//
//  state       | meaning
//  ------------+--------------------------------------------------
//  ENV_IDLE    | silent, level forced to 0, waiting for gate
//  ENV_ATTACK  | level rises by ATTACK_STEP per tick up to 255
//  ENV_DECAY   | level falls by DECAY_STEP per tick to SUSTAIN_LVL
//  ENV_SUSTAIN | level held while the key is down
//  ENV_RELEASE | level falls by RELEASE_STEP per tick down to 0
module adsr_envelope
   import adsr_envelope_pkg::*;
#(
   parameter int TICK_DIV     = 12000,
   parameter int ATTACK_STEP  = 4,
   parameter int DECAY_STEP   = 1,
   parameter int SUSTAIN_LVL  = 160,
   parameter int RELEASE_STEP = 2
) (
   input  logic       clk,
   input  logic       n_rst,
   input  logic       en,
   input  logic       gate,
   input  logic       retrig,
   input  logic [7:0] sample_i,
   output logic [7:0] sample_o,
   output logic [7:0] env_o,
   output logic       active_o
);

   localparam logic [8:0] ATT9 = 9'(ATTACK_STEP);
   localparam logic [8:0] DEC9 = 9'(DECAY_STEP);
   localparam logic [8:0] SUS9 = 9'(SUSTAIN_LVL);
   localparam logic [8:0] REL9 = 9'(RELEASE_STEP);
   localparam logic [7:0] SUS8 = 8'(SUSTAIN_LVL);
   localparam logic [7:0] DEC8 = 8'(DECAY_STEP);
   localparam logic [7:0] REL8 = 8'(RELEASE_STEP);

   env_state_t  state_q, state_d;
   logic [7:0]  level_q, level_d;
   logic [7:0]  sample_o_q, sample_o_d;
   logic        tick;
   logic [8:0]  att_sum;
   logic signed [8:0]  diff;
   logic signed [16:0] diff_x;
   logic signed [16:0] lvl_x;
   logic signed [16:0] prod;
   logic signed [16:0] prod_shr;

   env_tick_gen #(
      .TICK_DIV (TICK_DIV)
   ) u_tick (
      .clk   (clk),
      .n_rst (n_rst),
      .en    (en),
      .tick  (tick)
   );

   // Next state and level; gate release beats retrig, everything frozen when disabled.
   always_comb begin
      state_d = state_q;
      level_d = level_q;
      att_sum = {1'b0, level_q} + ATT9;
      if (en) begin
         case (state_q)
            ENV_IDLE: begin
               level_d = '0;
               if (gate) state_d = ENV_ATTACK;
            end
            ENV_ATTACK: begin
               if (!gate) begin
                  state_d = ENV_RELEASE;
               end else if (tick) begin
                  if (att_sum >= 9'd255) begin
                     level_d = 8'hFF;
                     state_d = ENV_DECAY;
                  end else begin
                     level_d = att_sum[7:0];
                  end
               end
            end
            ENV_DECAY: begin
               if (!gate) begin
                  state_d = ENV_RELEASE;
               end else if (retrig) begin
                  state_d = ENV_ATTACK;
               end else if (tick) begin
                  if ({1'b0, level_q} <= SUS9 + DEC9) begin
                     level_d = SUS8;
                     state_d = ENV_SUSTAIN;
                  end else begin
                     level_d = level_q - DEC8;
                  end
               end
            end
            ENV_SUSTAIN: begin
               if (!gate) begin
                  state_d = ENV_RELEASE;
               end else if (retrig) begin
                  state_d = ENV_ATTACK;
               end
            end
            ENV_RELEASE: begin
               if (gate) begin
                  state_d = ENV_ATTACK;
               end else if (tick) begin
                  if ({1'b0, level_q} <= REL9) begin
                     level_d = '0;
                     state_d = ENV_IDLE;
                  end else begin
                     level_d = level_q - REL8;
                  end
               end
            end
            default: begin
               state_d = ENV_IDLE;
               level_d = '0;
            end
         endcase
      end
   end

   // Scale the sample about midscale; |p>>>8| stays within 0..254 after re-centring.
   always_comb begin
      diff       = $signed({1'b0, sample_i}) - $signed({1'b0, MIDSCALE});
      diff_x     = 17'(diff);
      lvl_x      = $signed({9'd0, level_q});
      prod       = diff_x * lvl_x;
      prod_shr   = prod >>> 8;
      sample_o_d = MIDSCALE + prod_shr[7:0];
   end

   // State, level and output sample registers.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q    <= ENV_IDLE;
         level_q    <= '0;
         sample_o_q <= MIDSCALE;
      end else begin
         state_q    <= state_d;
         level_q    <= level_d;
         sample_o_q <= sample_o_d;
      end
   end

   assign sample_o = sample_o_q;
   assign env_o    = level_q;
   assign active_o = (state_q != ENV_IDLE);

endmodule

// File: tb/tb_adsr_envelope.sv
// Directed bench for adsr_envelope with a fast tick (TICK_DIV=4).
module tb_adsr_envelope;

   logic       clk = 1'b0;
   logic       n_rst;
   logic       en;
   logic       gate;
   logic       retrig;
   logic [7:0] sample_i;
   logic [7:0] sample_o;
   logic [7:0] env_o;
   logic       active_o;

   int n_cmp = 0;
   int n_bad = 0;

   adsr_envelope #(
      .TICK_DIV     (4),
      .ATTACK_STEP  (64),
      .DECAY_STEP   (16),
      .SUSTAIN_LVL  (160),
      .RELEASE_STEP (32)
   ) dut (
      .clk      (clk),
      .n_rst    (n_rst),
      .en       (en),
      .gate     (gate),
      .retrig   (retrig),
      .sample_i (sample_i),
      .sample_o (sample_o),
      .env_o    (env_o),
      .active_o (active_o)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input int obs, input int exp_v);
      n_cmp++;
      if (obs != exp_v) begin
         n_bad++;
         $display("FAIL %s: got %0d want %0d", tag, obs, exp_v);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Wait for env_o to move, then check new value and (optionally) edges taken.
   task automatic wait_env(input string tag, input int exp_v, input int exp_gap);
      logic [7:0] prev;
      int cyc;
      prev = env_o;
      cyc  = 0;
      while (env_o == prev && cyc < 40) begin
         step();
         cyc++;
      end
      check_eq({tag, " moved"}, int'(env_o != prev), 1);
      check_eq({tag, " level"}, int'(env_o), exp_v);
      if (exp_gap >= 0) check_eq({tag, " gap"}, cyc, exp_gap);
   endtask

   initial begin
      int changes;
      logic [7:0] ref_env;

      n_rst    = 1'b0;
      en       = 1'b1;
      gate     = 1'b0;
      retrig   = 1'b0;
      sample_i = 8'd128;
      step();
      step();
      check_eq("rst env", int'(env_o), 0);
      check_eq("rst active", int'(active_o), 0);
      check_eq("rst sample", int'(sample_o), 128);
      n_rst = 1'b1;

      // Attack, decay, sustain, with scaling checks in the quiet edges.
      gate = 1'b1;
      wait_env("att1", 64, -1);
      wait_env("att2", 128, 4);
      sample_i = 8'd0;
      #1 check_eq("lat old", int'(sample_o), 128);
      step();
      check_eq("scale e128 s0", int'(sample_o), 64);
      wait_env("att3", 192, 3);
      wait_env("att4", 255, 4);
      sample_i = 8'd255;
      step();
      check_eq("scale e255 s255", int'(sample_o), 254);
      sample_i = 8'd0;
      step();
      check_eq("scale e255 s0", int'(sample_o), 0);
      sample_i = 8'd128;
      step();
      check_eq("scale e255 s128", int'(sample_o), 128);
      wait_env("dec1", 239, 1);
      wait_env("dec2", 223, 4);
      wait_env("dec3", 207, 4);

      // Freeze mid-decay.
      en = 1'b0;
      changes = 0;
      ref_env = env_o;
      for (int i = 0; i < 50; i++) begin
         step();
         if (env_o != ref_env) changes++;
      end
      check_eq("freeze changes", changes, 0);
      check_eq("freeze env", int'(env_o), 207);
      check_eq("freeze active", int'(active_o), 1);
      en = 1'b1;
      wait_env("dec4", 191, 4);
      wait_env("dec5", 175, 4);
      wait_env("dec6 clamp", 160, 4);

      changes = 0;
      for (int i = 0; i < 80; i++) begin
         step();
         if (env_o != 8'd160) changes++;
      end
      check_eq("sustain changes", changes, 0);
      check_eq("sustain env", int'(env_o), 160);

      // Release to idle.
      gate = 1'b0;
      step();
      check_eq("rel enter env", int'(env_o), 160);
      check_eq("rel enter active", int'(active_o), 1);
      wait_env("rel1", 128, 3);
      wait_env("rel2", 96, 4);
      wait_env("rel3", 64, 4);
      wait_env("rel4", 32, 4);
      wait_env("rel5", 0, 4);
      check_eq("idle active", int'(active_o), 0);

      // Re-press during release, then retrig with gate low.
      gate = 1'b1;
      wait_env("re att1", 64, -1);
      wait_env("re att2", 128, 4);
      gate = 1'b0;
      step();
      check_eq("re rel env", int'(env_o), 128);
      wait_env("re rel1", 96, 3);
      gate = 1'b1;
      step();
      check_eq("repress keep", int'(env_o), 96);
      wait_env("repress att", 160, 3);
      gate   = 1'b0;
      retrig = 1'b1;
      step();
      retrig = 1'b0;
      check_eq("gate wins env", int'(env_o), 160);
      wait_env("gate wins rel", 128, 3);
      wait_env("rel b2", 96, 4);
      wait_env("rel b3", 64, 4);
      wait_env("rel b4", 32, 4);
      wait_env("rel b5", 0, 4);
      check_eq("idle2 active", int'(active_o), 0);

      // Async reset mid-attack.
      sample_i = 8'd255;
      gate     = 1'b1;
      wait_env("r att1", 64, -1);
      wait_env("r att2", 128, 4);
      step();
      check_eq("pre rst sample", int'(sample_o), 191);
      #2 n_rst = 1'b0;
      #1;
      check_eq("async rst sample", int'(sample_o), 128);
      check_eq("async rst env", int'(env_o), 0);
      check_eq("async rst active", int'(active_o), 0);
      step();
      n_rst = 1'b1;
      check_eq("post rst env", int'(env_o), 0);
      step();
      check_eq("post rst active", int'(active_o), 1);
      wait_env("restart att", 64, 3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
